ual_result_acc: RTL

//  Downstream stage of the 4-bit UAL. Captures each UAL result (SUM or MULT, chosen by op)

---
 rtl/ual_result_acc_if.sv | 36 +++
 rtl/ual_result_acc.sv | 104 ++++++++++
 2 files changed

// File: rtl/ual_result_acc_if.sv
// Handshake/bus bundle between the UAL result producer, the result
// accumulator FIFO and its consumer. The producer/consumer side uses the
// master modport; the accumulator block uses the slave modport.
interface ual_result_acc_if #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
);
    localparam int CW = $clog2(DEPTH) + 1;

    // producer side
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [4:0]       sum;
    logic [7:0]       mult;
    logic             clear;
    // consumer side
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_op;
    // status
    logic [ACC_W-1:0] acc;
    logic             acc_sat;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, op, sum, mult, clear, out_ready,
        input  in_ready, out_valid, out_data, out_op, acc, acc_sat, count
    );

    modport slave (
        input  in_valid, op, sum, mult, clear, out_ready,
        output in_ready, out_valid, out_data, out_op, acc, acc_sat, count
    );
endinterface

// File: rtl/ual_result_acc.sv
// UAL result capture stage: valid/ready input into a DEPTH-entry FIFO,
// valid/ready output to a slower sink, plus a saturating running total
// of every accepted result with a sticky saturation flag.
module ual_result_acc #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    ual_result_acc_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    typedef struct packed {
        logic       op;
        logic [7:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q;
    logic   [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic   [CW-1:0]    count_q, count_d;
    logic   [ACC_W-1:0] acc_q, acc_d;
    logic               sat_q, sat_d;

    logic               push, pop;
    logic [7:0]         res;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W:0]     acc_sum;
    entry_t             head;

    // Ready depends only on registered occupancy: a full FIFO refuses even
    // when a pop happens in the same cycle.
    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign res  = bus.op ? {3'b000, bus.sum} : bus.mult;
    assign head = bus.out_valid ? mem_q[rd_ptr_q] : '0;

    assign bus.out_data = head.data;
    assign bus.out_op   = head.op;
    assign bus.count    = count_q;
    assign bus.acc      = acc_q;
    assign bus.acc_sat  = sat_q;

    // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear is applied before the add, so clear+push starts the total at res.
    always_comb begin
        acc_base = bus.clear ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(res);
        acc_d    = acc_base;
        sat_d    = bus.clear ? 1'b0 : sat_q;
        if (push) begin
            if (acc_sum > {1'b0, ACC_MAX}) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{op: bus.op, data: res};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Running total and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end
endmodule
